// File: rtl/pixel_threshold_map.sv
// Streaming per-frame pixel mapper (white / black / passthrough / threshold), one register stage.
// Optional foreground counter is built only when PIXMAP_COUNT_EN is defined.
module pixel_threshold_map #(
    parameter int PIX_W = 8,
    parameter int LANES = 1,
    parameter int CNT_W = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [PIX_W-1:0]       thresh,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*PIX_W-1:0] s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*PIX_W-1:0] m_data,
    output logic                   m_last,
    output logic [CNT_W-1:0]       fg_count,
    output logic                   fg_valid
);

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    localparam logic [1:0] MODE_WHITE  = 2'b00;
    localparam logic [1:0] MODE_BLACK  = 2'b01;
    localparam logic [1:0] MODE_PASS   = 2'b10;
    localparam logic [1:0] MODE_THRESH = 2'b11;

    state_t                 state;
    logic [1:0]             frame_mode;
    logic [PIX_W-1:0]       frame_thresh;
    logic                   accept;
    logic [1:0]             eff_mode;
    logic [PIX_W-1:0]       eff_thresh;
    logic [LANES*PIX_W-1:0] mapped;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // The first beat of a frame uses the live controls; later beats use the latched copy.
    assign eff_mode   = (state == IDLE) ? mode   : frame_mode;
    assign eff_thresh = (state == IDLE) ? thresh : frame_thresh;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        mapped = '0;
        for (int i = 0; i < LANES; i++) begin
            unique case (eff_mode)
                MODE_WHITE:  mapped[i*PIX_W +: PIX_W] = '1;
                MODE_BLACK:  mapped[i*PIX_W +: PIX_W] = '0;
                MODE_PASS:   mapped[i*PIX_W +: PIX_W] = s_data[i*PIX_W +: PIX_W];
                MODE_THRESH: mapped[i*PIX_W +: PIX_W] =
                                 (s_data[i*PIX_W +: PIX_W] >= eff_thresh) ? '1 : '0;
                default:     mapped[i*PIX_W +: PIX_W] = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            frame_mode   <= MODE_WHITE;
            frame_thresh <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                frame_mode   <= mode;
                frame_thresh <= thresh;
            end
            state <= s_last ? IDLE : IN_FRAME;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= mapped;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef PIXMAP_COUNT_EN
    localparam int LW    = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + LW;

    logic [LW-1:0]    fg_lanes;
    logic [CNT_W-1:0] acc;
    logic [SUM_W-1:0] wide_sum;
    logic [CNT_W-1:0] sat_sum;

    always_comb begin
        fg_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mapped[i*PIX_W +: PIX_W] == {PIX_W{1'b1}}) begin
                fg_lanes = fg_lanes + LW'(1);
            end
        end
    end

    // Any carry above CNT_W means the frame total no longer fits: clamp to all ones.
    assign wide_sum = SUM_W'(acc) + SUM_W'(fg_lanes);
    assign sat_sum  = (|wide_sum[SUM_W-1:CNT_W]) ? '1 : wide_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            fg_count <= '0;
            fg_valid <= 1'b0;
        end else begin
            fg_valid <= 1'b0;
            if (accept) begin
                if (s_last) begin
                    fg_count <= sat_sum;
                    fg_valid <= 1'b1;
                    acc      <= '0;
                end else begin
                    acc <= sat_sum;
                end
            end
        end
    end
`else
    assign fg_count = '0;
    assign fg_valid = 1'b0;
`endif

endmodule
